// File: rtl/serial_link_credit_rx_buffer.sv
// serial_link_credit_rx_buffer
//   Receive side of the serial link's credit-based flow control. Incoming
//   packets from the deserializer are either data (payload stored in a
//   NumCredits-deep FIFO) or credit-only. Credits piggybacked by the remote
//   side are forwarded to the local transmitter as a one-cycle pulse. Slots
//   freed by the consumer are counted so the local transmitter can return
//   them to the remote side.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rx_valid_i / rx_ready_o      incoming packet handshake (ready is registered)
//   rx_is_data_i                 1: packet has payload, 0: credit-only
//   rx_data_i                    packet payload
//   rx_credits_i                 credits piggybacked by the remote side
//   deq_valid_o / deq_ready_i    FIFO head handshake toward the protocol layer
//   deq_data_o                   FIFO head payload (0 while empty)
//   credits_returned_valid_o     one-cycle pulse qualifying credits_returned_o
//   credits_returned_o           last nonzero credit count received
//   credits_freed_o              slots freed since the last ack
//   credits_freed_ack_i          local tx has sent credits_freed_o
//   count_o                      FIFO occupancy
//   overflow_o                   sticky: data arrived with no free slot
module serial_link_credit_rx_buffer #(
  parameter int DataWidth   = 32,
  parameter int NumCredits  = 8,
  parameter int CreditWidth = $clog2(NumCredits + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic                   rx_is_data_i,
  input  logic [DataWidth-1:0]   rx_data_i,
  input  logic [CreditWidth-1:0] rx_credits_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output logic [DataWidth-1:0]   deq_data_o,
  output logic                   credits_returned_valid_o,
  output logic [CreditWidth-1:0] credits_returned_o,
  output logic [CreditWidth-1:0] credits_freed_o,
  input  logic                   credits_freed_ack_i,
  output logic [CreditWidth-1:0] count_o,
  output logic                   overflow_o
);

  localparam int IdxW = $clog2(NumCredits);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NumCredits - 1);
  localparam logic [CreditWidth-1:0] Full  = CreditWidth'(NumCredits);
  localparam logic [CreditWidth:0] FullExt = (CreditWidth + 1)'(NumCredits);

  // Pointer MSB is a wrap bit: equal index with differing wrap bits means full.
  function automatic logic [IdxW:0] next_ptr(input logic [IdxW:0] p);
    if (p[IdxW-1:0] == LastIdx) return {~p[IdxW], {IdxW{1'b0}}};
    return p + (IdxW + 1)'(1);
  endfunction

  logic [DataWidth-1:0]   mem [NumCredits];
  logic [IdxW:0]          wr_ptr_q, rd_ptr_q;
  logic [CreditWidth-1:0] count_q, freed_q;
  logic                   rdy_q, ovf_q;
  logic                   vld_p1;
  logic [CreditWidth-1:0] cred_ret_p1;
  logic                   overdraft_q;

  logic                   rx_hs, deq_hs, wr_req, wr_en, cred_hit;
  logic [CreditWidth:0]   occupancy;

  assign rx_hs     = rx_valid_i & rdy_q;
  assign deq_hs    = deq_ready_i & (count_q != '0);
  assign wr_req    = rx_hs & rx_is_data_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en     = wr_req & ((count_q != Full) | deq_hs);
  assign cred_hit  = rx_hs & (rx_credits_i != '0);
  assign occupancy = {1'b0, count_q} + {1'b0, freed_q};

  // Stage p0 -> p1: control state, pointers, counters, credit pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdy_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      freed_q     <= '0;
      ovf_q       <= 1'b0;
      vld_p1      <= 1'b0;
      cred_ret_p1 <= '0;
      overdraft_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (wr_en)  wr_ptr_q <= next_ptr(wr_ptr_q);
      if (deq_hs) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (wr_en && !deq_hs)      count_q <= count_q + CreditWidth'(1);
      else if (!wr_en && deq_hs) count_q <= count_q - CreditWidth'(1);
      if (wr_req && !wr_en) ovf_q <= 1'b1;
      vld_p1 <= cred_hit;
      if (cred_hit) cred_ret_p1 <= rx_credits_i;
      // An ack coinciding with a dequeue keeps that dequeue's credit.
      if (credits_freed_ack_i) freed_q <= deq_hs ? CreditWidth'(1) : '0;
      else if (deq_hs)         freed_q <= freed_q + CreditWidth'(1);
      // Remote wrote while holding no credit; occupancy invariant no longer applies.
      if (wr_en && (occupancy >= FullExt)) overdraft_q <= 1'b1;
    end
  end

  // Payload storage carries no reset; head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q[IdxW-1:0]] <= rx_data_i;
  end

  assign rx_ready_o               = rdy_q;
  assign deq_valid_o              = (count_q != '0);
  assign deq_data_o               = (count_q != '0) ? mem[rd_ptr_q[IdxW-1:0]] : '0;
  assign credits_returned_valid_o = vld_p1;
  assign credits_returned_o       = cred_ret_p1;
  assign credits_freed_o          = freed_q;
  assign count_o                  = count_q;
  assign overflow_o               = ovf_q;

  a_count_range: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= Full);
  a_freed_range: assert property (@(posedge clk_i) disable iff (rst_i) freed_q <= Full);
  a_freed_nowrap: assert property (@(posedge clk_i) disable iff (rst_i)
    (deq_hs && !credits_freed_ack_i) |-> (freed_q != Full));
  a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i)
    !overdraft_q |-> (occupancy <= FullExt));
  a_ptr_full: assert property (@(posedge clk_i) disable iff (rst_i)
    (count_q == Full) == ((wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                          (wr_ptr_q[IdxW] != rd_ptr_q[IdxW])));

endmodule

// File: tb/tb_serial_link_credit_rx_buffer.sv
module tb_serial_link_credit_rx_buffer;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0, rx_is_data = 1'b0, deq_ready = 1'b0, ack = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [CW-1:0] rx_credits = '0;
  logic          rx_ready_o, deq_valid_o, cr_valid_o, overflow_o;
  logic [DW-1:0] deq_data_o;
  logic [CW-1:0] cr_o, freed_o, count_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of payloads plus scalar bookkeeping.
  logic [DW-1:0] mq[$];
  int  m_freed = 0, m_cr = 0;
  bit  m_ovf = 0, m_rdy = 0, m_crv = 0;

  serial_link_credit_rx_buffer #(.DataWidth(DW), .NumCredits(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o), .rx_is_data_i(rx_is_data),
    .rx_data_i(rx_data), .rx_credits_i(rx_credits),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready), .deq_data_o(deq_data_o),
    .credits_returned_valid_o(cr_valid_o), .credits_returned_o(cr_o),
    .credits_freed_o(freed_o), .credits_freed_ack_i(ack),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  logic [47:0] dut_vec;
  assign dut_vec = {rx_ready_o, deq_valid_o, deq_data_o, cr_valid_o, cr_o, freed_o, count_o, overflow_o};

  function automatic logic [47:0] exp_vec();
    logic [DW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    return {m_rdy, mq.size() != 0, head, m_crv, CW'(m_cr), CW'(m_freed), CW'(mq.size()), m_ovf};
  endfunction

  // Advance one clock: model consumes the inputs presented now, DUT samples them at the edge.
  task automatic step();
    bit hs, dq;
    hs = rx_valid && m_rdy;
    dq = deq_ready && (mq.size() != 0);
    if (rst) begin
      mq.delete(); m_freed = 0; m_cr = 0; m_ovf = 0; m_rdy = 0; m_crv = 0;
    end else begin
      if (hs && rx_is_data) begin
        if (mq.size() < N || dq) mq.push_back(rx_data);
        else m_ovf = 1;
      end
      if (dq) void'(mq.pop_front());
      m_crv = hs && (rx_credits != 0);
      if (m_crv) m_cr = rx_credits;
      m_freed = ack ? int'(dq) : m_freed + int'(dq);
      m_rdy = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_valid = 0; rx_is_data = 0; rx_credits = 0; deq_ready = 0; ack = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0; step();
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    rx_valid = 1; rx_is_data = 1; rx_data = d; rx_credits = 0;
    step();
    rx_valid = 0; rx_is_data = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step();
    vectors++;
    if (dut_vec !== 48'h0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    rst = 0; step();
    vectors++;
    if (rx_ready_o !== 1'b1 || count_o !== 4'd0) begin
      miscompares++; $display("FAIL reset_release: rx_ready=%b count=%0d expected 1/0", rx_ready_o, count_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < N; i++) send_data(32'hA000_0000 + i);
    vectors++;
    if (count_o !== 4'd8 || overflow_o !== 1'b0) begin
      miscompares++; $display("FAIL fill_count: count=%0d ovf=%b expected 8/0", count_o, overflow_o);
    end
    send_data(32'hDEAD_BEEF);
    vectors++;
    if (count_o !== 4'd8 || overflow_o !== 1'b1) begin
      miscompares++; $display("FAIL overflow_set: count=%0d ovf=%b expected 8/1", count_o, overflow_o);
    end
    deq_ready = 1; ack = 1;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (deq_valid_o !== 1'b1 || deq_data_o !== 32'hA000_0000 + i) begin
        miscompares++; $display("FAIL drain_order[%0d]: got %h v=%b expected %h", i, deq_data_o, deq_valid_o, 32'hA000_0000 + i);
      end
      step();
    end
    idle(); step();
    vectors++;
    if (deq_valid_o !== 1'b0 || overflow_o !== 1'b1 || dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL overflow_sticky: got %h expected %h", dut_vec, exp_vec());
    end
    do_reset();
  endtask

  task automatic test_credit_only();
    rx_valid = 1; rx_is_data = 0; rx_data = 32'h1234_5678; rx_credits = 3;
    step();
    vectors++;
    if (cr_valid_o !== 1'b1 || cr_o !== 4'd3 || count_o !== 4'd0) begin
      miscompares++; $display("FAIL credit_pulse: v=%b cr=%0d count=%0d expected 1/3/0", cr_valid_o, cr_o, count_o);
    end
    rx_credits = 0;
    step();
    vectors++;
    if (cr_valid_o !== 1'b0 || cr_o !== 4'd3) begin
      miscompares++; $display("FAIL zero_credit: v=%b cr=%0d expected 0/3", cr_valid_o, cr_o);
    end
    idle(); step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++; $display("FAIL credit_idle: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_freed();
    for (int i = 0; i < 5; i++) send_data(32'hB000_0000 + i);
    deq_ready = 1;
    repeat (3) step();
    deq_ready = 0;
    vectors++;
    if (freed_o !== 4'd3 || count_o !== 4'd2) begin
      miscompares++; $display("FAIL freed_count: freed=%0d count=%0d expected 3/2", freed_o, count_o);
    end
    ack = 1; step();
    vectors++;
    if (freed_o !== 4'd0) begin
      miscompares++; $display("FAIL freed_ack: freed=%0d expected 0", freed_o);
    end
    deq_ready = 1; step();
    vectors++;
    if (freed_o !== 4'd1 || count_o !== 4'd1) begin
      miscompares++; $display("FAIL freed_ack_deq: freed=%0d count=%0d expected 1/1", freed_o, count_o);
    end
    idle(); do_reset();
  endtask

  task automatic test_full_simultaneous();
    int sent, expd, budget;
    for (int i = 0; i < N; i++) send_data(32'h100 + i);
    rx_valid = 1; rx_is_data = 1; rx_data = 32'h1FF; deq_ready = 1; ack = 1;
    step();
    idle();
    vectors++;
    if (count_o !== 4'd8 || overflow_o !== 1'b0 || deq_data_o !== 32'h101) begin
      miscompares++; $display("FAIL full_wr_deq: count=%0d ovf=%b head=%h expected 8/0/101", count_o, overflow_o, deq_data_o);
    end
    do_reset();
    // Stream 0..19 with random consumer stalls; remote only sends while it holds credit.
    sent = 0; expd = 0; budget = 400;
    while (expd < 20 && budget > 0) begin
      budget--;
      deq_ready = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      rx_valid = (sent < 20) && (mq.size() + m_freed < N);
      rx_is_data = 1; rx_data = sent; rx_credits = 0;
      if (deq_ready && deq_valid_o) begin
        vectors++;
        if (deq_data_o !== 32'(expd)) begin
          miscompares++; $display("FAIL stream_order: got %0d expected %0d", deq_data_o, expd);
        end
        expd++;
      end
      if (rx_valid) sent++;
      step();
    end
    idle();
    vectors++;
    if (budget == 0) begin
      miscompares++; $display("FAIL stream_budget: drained %0d expected 20", expd);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rx_valid   = 1'($urandom_range(0, 1));
      rx_is_data = 1'($urandom_range(0, 1)) && (mq.size() + m_freed < N);
      rx_data    = $urandom;
      rx_credits = CW'($urandom_range(0, N));
      deq_ready  = 1'($urandom_range(0, 1));
      ack        = ($urandom_range(0, 3) == 0);
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL random[%0d]: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    idle(); step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) send_data(32'hC000_0000 + i);
    deq_ready = 1; repeat (2) step(); deq_ready = 0;
    vectors++;
    if (count_o !== 4'd5 || freed_o !== 4'd2) begin
      miscompares++; $display("FAIL mid_setup: count=%0d freed=%0d expected 5/2", count_o, freed_o);
    end
    rst = 1; rx_valid = 1; rx_is_data = 0; rx_credits = 5;
    step();
    idle();
    vectors++;
    if (count_o !== 4'd0 || deq_valid_o !== 1'b0 || freed_o !== 4'd0 || cr_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: count=%0d dv=%b freed=%0d crv=%b expected 0/0/0/0",
                              count_o, deq_valid_o, freed_o, cr_valid_o);
    end
    rst = 0; step();
    vectors++;
    if (dut_vec !== exp_vec() || rx_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL mid_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_credit_only();
    test_freed();
    test_full_simultaneous();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
